// File: rtl/ws2812_pkg.sv
// Shared types for the WS2812 frame-buffer arbiter: GRB color word and FSM states.
package ws2812_pkg;

  localparam int CNT_LEDS_DEF = 64;

  // G in [23:16], R in [15:8], B in [7:0]
  typedef logic [23:0] color_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/ws2812_fb_arb_if.sv
// Host-write and serializer-fetch signals of the frame-buffer arbiter; master = host/serializer side.
interface ws2812_fb_arb_if #(
  parameter int ADDR_W = 6
);
  import ws2812_pkg::*;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  color_t            wr_color;
  logic              wr_ack;
  logic [ADDR_W-1:0] leddata_addr;
  logic              leddata_start;
  color_t            leddata_color;
  logic              frame_commit;
  logic              commit_done;

  modport master (
    output wr_req, wr_addr, wr_color, leddata_addr, leddata_start, frame_commit,
    input  wr_ack, leddata_color, commit_done
  );

  modport slave (
    input  wr_req, wr_addr, wr_color, leddata_addr, leddata_start, frame_commit,
    output wr_ack, leddata_color, commit_done
  );

endinterface

// File: rtl/ws2812_fb_ram.sv
// Single-port synchronous frame-buffer RAM, 1-cycle read latency; contents are never reset.
module ws2812_fb_ram
  import ws2812_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  color_t        wdata,
  output color_t        rdata
);

  color_t mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ws2812_fb_arb.sv
// Arbitrates one RAM access per cycle between serializer fetches (priority, color after 3 clk) and host writes.
// WS2812_DBLBUF_EN adds a second bank: fetches read the front bank, writes fill the back bank, frame_commit swaps.
module ws2812_fb_arb
  import ws2812_pkg::*;
#(
  parameter int CNT_LEDS = CNT_LEDS_DEF,
  parameter int ADDR_W   = $clog2(CNT_LEDS)
) (
  input logic            clk,
  input logic            rst_n,
  ws2812_fb_arb_if.slave bus
);

`ifdef WS2812_DBLBUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int RAM_AW = $clog2(NBANK * CNT_LEDS);

  state_t            state;
  state_t            state_nxt;
  logic              start_q;
  logic              start_edge;
  logic              fetch_pend;
  logic [ADDR_W-1:0] fetch_addr;
  color_t            color_q;
  color_t            ram_rdata;
  logic              ram_en;
  logic              ram_we;
  logic              wr_ack;
  logic [RAM_AW-1:0] ram_addr;

  assign start_edge = bus.leddata_start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A fetch (fresh edge or one held pending) always beats a waiting write.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_edge || fetch_pend) begin
          state_nxt = ST_FETCH;
        end else if (bus.wr_req) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en = 1'b0;
    ram_we = 1'b0;
    wr_ack = 1'b0;
    case (state)
      ST_FETCH: ram_en = 1'b1;
      ST_WRITE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        wr_ack = 1'b1;
      end
      default: ;
    endcase
  end

  // Edges seen outside IDLE are parked in fetch_pend; the address is captured at the edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      fetch_pend <= 1'b0;
      fetch_addr <= '0;
      color_q    <= '0;
    end else begin
      start_q <= bus.leddata_start;
      if (start_edge) begin
        fetch_addr <= bus.leddata_addr;
      end
      if (state == ST_IDLE) begin
        fetch_pend <= 1'b0;
      end else if (start_edge) begin
        fetch_pend <= 1'b1;
      end
      if (state == ST_LATCH) begin
        color_q <= ram_rdata;
      end
    end
  end

`ifdef WS2812_DBLBUF_EN
  logic              bank_sel;
  logic              commit_pend;
  logic              commit_done;
  logic              swap;
  logic              fetch_go;
  logic [ADDR_W-1:0] fetch_addr_nxt;

  assign fetch_addr_nxt = start_edge ? bus.leddata_addr : fetch_addr;
  assign fetch_go       = (state == ST_IDLE) && (state_nxt == ST_FETCH);
  // Swap lands on the FETCH entry edge, so the addr-0 read already sees the new front bank.
  assign swap           = fetch_go && commit_pend && (fetch_addr_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel    <= 1'b0;
      commit_pend <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= swap;
      if (swap) begin
        bank_sel <= ~bank_sel;
      end
      commit_pend <= (commit_pend & ~swap) | bus.frame_commit;
    end
  end

  assign ram_addr        = (state == ST_WRITE) ? {~bank_sel, bus.wr_addr} : {bank_sel, fetch_addr};
  assign bus.commit_done = commit_done;
`else
  logic unused_commit;

  assign unused_commit   = bus.frame_commit;
  assign ram_addr        = (state == ST_WRITE) ? bus.wr_addr : fetch_addr;
  assign bus.commit_done = 1'b0;
`endif

  ws2812_fb_ram #(
    .AW    (RAM_AW),
    .DEPTH (NBANK * CNT_LEDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.wr_color),
    .rdata (ram_rdata)
  );

  assign bus.wr_ack        = wr_ack;
  assign bus.leddata_color = color_q;

endmodule

// File: tb/tb_ws2812_fb_arb.sv
// Directed + randomized bench for ws2812_fb_arb against a bank-array reference model.
module tb_ws2812_fb_arb;
  import ws2812_pkg::*;

`ifdef WS2812_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ws2812_fb_arb_if #(.ADDR_W(6)) bus ();

  ws2812_fb_arb #(.CNT_LEDS(64), .ADDR_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frame contents per bank, front bank index, pending commit.
  color_t     mem_m [2][64];
  int         front_m = 0;
  bit         cpend_m = 1'b0;

  bit         wr_busy = 1'b0;
  logic [5:0] w_a;
  color_t     w_c;
  int         ack_cnt = 0;
  bit         done_seen = 1'b0;

  function automatic int back_bank();
    return DBL ? 1 - front_m : front_m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, act as host (retire write on ack).
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.commit_done === 1'b1) done_seen = 1'b1;
    if (bus.wr_ack === 1'b1) begin
      ack_cnt++;
      if (wr_busy) begin
        mem_m[back_bank()][w_a] = w_c;
        wr_busy    = 1'b0;
        bus.wr_req = 1'b0;
      end
    end
  endtask

  task automatic start_write(input logic [5:0] a, input color_t c);
    w_a          = a;
    w_c          = c;
    wr_busy      = 1'b1;
    bus.wr_addr  = a;
    bus.wr_color = c;
    bus.wr_req   = 1'b1;
  endtask

  task automatic do_write(input logic [5:0] a, input color_t c);
    int n;
    int a0;
    a0 = ack_cnt;
    n  = 0;
    start_write(a, c);
    while (wr_busy && n < 8) begin
      tick();
      n++;
    end
    check("wr_ack_latency", n, 1);
    tick();
    check("wr_ack_single_pulse", ack_cnt - a0, 1);
  endtask

  task automatic do_commit();
    bus.frame_commit = 1'b1;
    tick();
    bus.frame_commit = 1'b0;
    if (DBL) cpend_m = 1'b1;
  endtask

  task automatic do_fetch(input logic [5:0] a, input int steps, input string tag);
    color_t exp;
    bit     exp_done;
    exp_done = 1'b0;
    if (a == 6'd0 && cpend_m) begin
      front_m  = 1 - front_m;
      cpend_m  = 1'b0;
      exp_done = 1'b1;
    end
    exp               = mem_m[front_m][a];
    done_seen         = 1'b0;
    bus.leddata_addr  = a;
    bus.leddata_start = 1'b1;
    repeat (steps) tick();
    check(tag, bus.leddata_color, exp);
    check({tag, "_commit_done"}, done_seen, exp_done);
    bus.leddata_start = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    color_t     c;
    logic [6:0] a7;
    int         n;
    int         a0;

    rst_n             = 1'b0;
    bus.wr_req        = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_color      = '0;
    bus.leddata_addr  = '0;
    bus.leddata_start = 1'b0;
    bus.frame_commit  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_color", bus.leddata_color, 0);
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_commit_done", bus.commit_done, 0);
    rst_n = 1'b1;
    tick();

    // Fill every bank with random data so all later reads are defined.
    for (int b = 0; b < (DBL ? 2 : 1); b++) begin
      for (int a = 0; a < 64; a++) do_write(6'(a), 24'($urandom));
      do_commit();
      do_fetch(6'd0, 3, "fill_swap");
    end

    // Idle write then fetch of the same LED.
    do_write(6'd5, 24'h00FF00);
    do_commit();
    do_fetch(6'd0, 3, "basic_swap");
    do_fetch(6'd5, 3, "basic_fetch");
    check("basic_const", bus.leddata_color, 24'h00FF00);

    // Write and fetch edge in the same cycle: fetch wins and returns the pre-write value.
    do_write(6'd3, 24'hABCDEF);
    do_commit();
    do_fetch(6'd0, 3, "coinc_swap");
    start_write(6'd3, 24'h123456);
    bus.leddata_addr  = 6'd3;
    bus.leddata_start = 1'b1;
    n = 0;
    repeat (3) begin
      tick();
      n++;
    end
    check("coinc_color", bus.leddata_color, 24'hABCDEF);
    while (wr_busy && n < 10) begin
      tick();
      n++;
    end
    check("coinc_ack_cycle", n, 4);
    bus.leddata_start = 1'b0;
    tick();
    do_fetch(6'd3, 3, "coinc_after");

    // Fetch edges overlapping writes at every phase offset; none may be dropped.
    for (int i = 0; i < 64; i++) begin
      start_write(6'((i + 1 + $urandom_range(0, 62)) % 64), 24'($urandom));
      repeat (i % 3) tick();
      do_fetch(6'(i), 5, "b2b_color");
      n = 0;
      while (wr_busy && n < 6) begin
        tick();
        n++;
      end
      check("b2b_write_done", wr_busy, 0);
    end

    // Commit mid-frame: the tail keeps old data, the swap happens at the addr-0 fetch.
    for (int a = 0; a < 64; a++) do_write(6'(a), 24'h0000FF);
    for (int a = 0; a < 30; a++) do_fetch(6'(a), 3, "frame_head");
    do_commit();
    do_commit();
    for (int a = 30; a < 64; a++) do_fetch(6'(a), 3, "frame_tail");
    do_fetch(6'd0, 3, "frame_new0");
    check("frame_new_const", bus.leddata_color, 24'h0000FF);
    do_fetch(6'd1, 3, "frame_new1");
    do_fetch(6'd0, 3, "frame_absorbed");

    // Reset during FETCH with a write waiting: both aborted, no ack.
    a0                = ack_cnt;
    bus.leddata_addr  = 6'd7;
    bus.leddata_start = 1'b1;
    start_write(6'd9, 24'h55AA55);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_color", bus.leddata_color, 0);
    check("midrst_wr_ack", bus.wr_ack, 0);
    check("midrst_commit_done", bus.commit_done, 0);
    bus.leddata_start = 1'b0;
    bus.wr_req        = 1'b0;
    wr_busy           = 1'b0;
    front_m           = 0;
    cpend_m           = 1'b0;
    repeat (2) tick();
    check("midrst_no_ack", ack_cnt - a0, 0);
    rst_n = 1'b1;
    tick();
    do_fetch(6'd7, 3, "postrst_fetch");
    do_fetch(6'd9, 3, "postrst_unwritten");

    // Out-of-range address wraps to index 0 of the back bank only.
    a7 = 7'd64;
    do_write(a7[5:0], 24'hC0FFEE);
    do_fetch(6'd0, 3, "wrap_front0");
    do_fetch(6'd1, 3, "wrap_front1");
    do_commit();
    do_fetch(6'd0, 3, "wrap_swapped0");
    check("wrap_const", bus.leddata_color, 24'hC0FFEE);

    // Random mix of writes, fetches and commits.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    do_write(6'($urandom_range(0, 63)), 24'($urandom));
        2:       do_fetch(6'($urandom_range(0, 63)), 3, "rand_fetch");
        default: begin
          do_commit();
          do_fetch(6'd0, 3, "rand_commit_fetch");
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
